// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and types for the ID->EX pipeline register.
// Holds the decoder encodings (branch type, destination select, writeback
// source) and the packed control bundle carried from ID to EX.
package id_ex_stage_pkg;

    // Branch-type codes; only the two the stage itself needs to recognise
    localparam logic [3:0] CB_NONE   = 4'd0;
    localparam logic [3:0] CB_JAL_BR = 4'd10;
    // A bubble carries "no branch"
    localparam logic [3:0] BUBBLE_CB = CB_NONE;

    // Destination select: rd field or rt field
    localparam logic REGWA_RD = 1'b0;
    localparam logic REGWA_RT = 1'b1;

    // Writeback source
    localparam logic [1:0] REGWD_ALU   = 2'd0;
    localparam logic [1:0] REGWD_MEMRD = 2'd1;
    localparam logic [1:0] REGWD_HI    = 2'd2;
    localparam logic [1:0] REGWD_LO    = 2'd3;

    // jal links into the return-address register
    localparam int unsigned JAL_LINK_REG = 32'd31;

    // Decoded control bundle, registered as one unit
    typedef struct packed {
        logic [3:0] cb;
        logic [1:0] alu1;
        logic       alu2;
        logic [3:0] alusel;
        logic       dmemwe;
        logic [1:0] memlen;
        logic       regwa;
        logic [1:0] regwd;
        logic       regwe;
    } ctrl_t;

    // Control bundle of a bubble: no writes, no branch
    localparam ctrl_t BUBBLE_CTRL = '{
        cb:     BUBBLE_CB,
        alu1:   2'b00,
        alu2:   1'b0,
        alusel: 4'b0000,
        dmemwe: 1'b0,
        memlen: 2'b00,
        regwa:  1'b0,
        regwd:  2'b00,
        regwe:  1'b0
    };

    // True when the writeback value comes from a data-memory read
    function automatic logic is_load_wb(input logic [1:0] regwd);
        return (regwd == REGWD_MEMRD);
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination is a
// source of the instruction in ID cannot forward in time, so ID must wait.
// Writes to register 0 never create a hazard.
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_regwe,
    input  logic [1:0]    ex_regwd,
    input  logic [AW-1:0] ex_wa,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    output logic          lu
);

    // Hazard when a real load in EX targets a nonzero register read by ID
    always_comb begin
        lu = 1'b0;
        if (ex_valid && ex_regwe && is_load_wb(ex_regwd) &&
            (ex_wa != {AW{1'b0}}) && id_valid &&
            ((ex_wa == id_rs) || (ex_wa == id_rt))) begin
            lu = 1'b1;
        end else begin
            lu = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register.
// Captures the decoded control bundle, operands and instruction fields,
// resolves the destination register and inserts bubbles on flush or
// load-use. hold freezes everything; flush beats load-use.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_cb,
    input  logic [1:0]    id_alu1,
    input  logic          id_alu2,
    input  logic [3:0]    id_alusel,
    input  logic          id_dmemwe,
    input  logic [1:0]    id_memlen,
    input  logic          id_regwa,
    input  logic [1:0]    id_regwd,
    input  logic          id_regwe,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [4:0]    id_sa,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc,
    output logic          ex_valid,
    output logic [3:0]    ex_cb,
    output logic [1:0]    ex_alu1,
    output logic          ex_alu2,
    output logic [3:0]    ex_alusel,
    output logic          ex_dmemwe,
    output logic [1:0]    ex_memlen,
    output logic          ex_regwa,
    output logic [1:0]    ex_regwd,
    output logic          ex_regwe,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic [4:0]    ex_sa,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc,
    output logic [AW-1:0] ex_wa,
    output logic          stall_id
);

    // Pipeline state
    logic          ex_valid_r;
    ctrl_t         ex_ctrl_r;
    logic [AW-1:0] ex_rs_r, ex_rt_r, ex_rd_r, ex_wa_r;
    logic [4:0]    ex_sa_r;
    logic [DW-1:0] ex_rd1_r, ex_rd2_r, ex_imm_r, ex_pc_r;

    // Next-state values
    logic          valid_nxt_s;
    ctrl_t         ctrl_nxt_s;
    logic [AW-1:0] rs_nxt_s, rt_nxt_s, rd_nxt_s, wa_nxt_s;
    logic [4:0]    sa_nxt_s;
    logic [DW-1:0] rd1_nxt_s, rd2_nxt_s, imm_nxt_s, pc_nxt_s;

    ctrl_t         id_ctrl_s;
    logic [AW-1:0] id_wa_s;
    logic          lu_s;

    assign id_ctrl_s = '{
        cb:     id_cb,
        alu1:   id_alu1,
        alu2:   id_alu2,
        alusel: id_alusel,
        dmemwe: id_dmemwe,
        memlen: id_memlen,
        regwa:  id_regwa,
        regwd:  id_regwd,
        regwe:  id_regwe
    };

    load_use_detect #(
        .AW (AW)
    ) u_load_use_detect (
        .ex_valid (ex_valid_r),
        .ex_regwe (ex_ctrl_r.regwe),
        .ex_regwd (ex_ctrl_r.regwd),
        .ex_wa    (ex_wa_r),
        .id_valid (id_valid),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .lu       (lu_s)
    );

    // Destination: jal links to r31, else rt or rd as the decoder selects
    always_comb begin
        id_wa_s = id_rd;
        if (id_cb == CB_JAL_BR) begin
            id_wa_s = AW'(JAL_LINK_REG);
        end else if (id_regwa == REGWA_RT) begin
            id_wa_s = id_rt;
        end else begin
            id_wa_s = id_rd;
        end
    end

    // Update priority: hold freezes, flush or load-use bubbles, else load
    always_comb begin
        valid_nxt_s = ex_valid_r;
        ctrl_nxt_s  = ex_ctrl_r;
        rs_nxt_s    = ex_rs_r;
        rt_nxt_s    = ex_rt_r;
        rd_nxt_s    = ex_rd_r;
        wa_nxt_s    = ex_wa_r;
        sa_nxt_s    = ex_sa_r;
        rd1_nxt_s   = ex_rd1_r;
        rd2_nxt_s   = ex_rd2_r;
        imm_nxt_s   = ex_imm_r;
        pc_nxt_s    = ex_pc_r;
        if (hold) begin
            valid_nxt_s = ex_valid_r;
        end else if (flush || lu_s) begin
            // Bubble: cleared like reset, but the PC still tracks ID
            valid_nxt_s = 1'b0;
            ctrl_nxt_s  = BUBBLE_CTRL;
            rs_nxt_s    = {AW{1'b0}};
            rt_nxt_s    = {AW{1'b0}};
            rd_nxt_s    = {AW{1'b0}};
            wa_nxt_s    = {AW{1'b0}};
            sa_nxt_s    = 5'd0;
            rd1_nxt_s   = {DW{1'b0}};
            rd2_nxt_s   = {DW{1'b0}};
            imm_nxt_s   = {DW{1'b0}};
            pc_nxt_s    = id_pc;
        end else begin
            valid_nxt_s = id_valid;
            ctrl_nxt_s  = id_ctrl_s;
            rs_nxt_s    = id_rs;
            rt_nxt_s    = id_rt;
            rd_nxt_s    = id_rd;
            wa_nxt_s    = id_wa_s;
            sa_nxt_s    = id_sa;
            rd1_nxt_s   = id_rd1;
            rd2_nxt_s   = id_rd2;
            imm_nxt_s   = id_imm;
            pc_nxt_s    = id_pc;
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= BUBBLE_CTRL;
            ex_rs_r    <= {AW{1'b0}};
            ex_rt_r    <= {AW{1'b0}};
            ex_rd_r    <= {AW{1'b0}};
            ex_wa_r    <= {AW{1'b0}};
            ex_sa_r    <= 5'd0;
            ex_rd1_r   <= {DW{1'b0}};
            ex_rd2_r   <= {DW{1'b0}};
            ex_imm_r   <= {DW{1'b0}};
            ex_pc_r    <= {DW{1'b0}};
        end else begin
            ex_valid_r <= valid_nxt_s;
            ex_ctrl_r  <= ctrl_nxt_s;
            ex_rs_r    <= rs_nxt_s;
            ex_rt_r    <= rt_nxt_s;
            ex_rd_r    <= rd_nxt_s;
            ex_wa_r    <= wa_nxt_s;
            ex_sa_r    <= sa_nxt_s;
            ex_rd1_r   <= rd1_nxt_s;
            ex_rd2_r   <= rd2_nxt_s;
            ex_imm_r   <= imm_nxt_s;
            ex_pc_r    <= pc_nxt_s;
        end
    end

    // A stall is only requested when the hazard actually blocks this cycle
    assign stall_id = lu_s & ~flush & ~hold;

    assign ex_valid  = ex_valid_r;
    assign ex_cb     = ex_ctrl_r.cb;
    assign ex_alu1   = ex_ctrl_r.alu1;
    assign ex_alu2   = ex_ctrl_r.alu2;
    assign ex_alusel = ex_ctrl_r.alusel;
    assign ex_dmemwe = ex_ctrl_r.dmemwe;
    assign ex_memlen = ex_ctrl_r.memlen;
    assign ex_regwa  = ex_ctrl_r.regwa;
    assign ex_regwd  = ex_ctrl_r.regwd;
    assign ex_regwe  = ex_ctrl_r.regwe;
    assign ex_rs     = ex_rs_r;
    assign ex_rt     = ex_rt_r;
    assign ex_rd     = ex_rd_r;
    assign ex_sa     = ex_sa_r;
    assign ex_rd1    = ex_rd1_r;
    assign ex_rd2    = ex_rd2_r;
    assign ex_imm    = ex_imm_r;
    assign ex_pc     = ex_pc_r;
    assign ex_wa     = ex_wa_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies directed then random
// stimulus and queues the expected EX contents and stall; separate monitors
// pop and compare.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, hold, flush, id_valid;
    logic [3:0]  id_cb, id_alusel;
    logic [1:0]  id_alu1, id_memlen, id_regwd;
    logic        id_alu2, id_dmemwe, id_regwa, id_regwe;
    logic [4:0]  id_rs, id_rt, id_rd, id_sa;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
    logic        ex_valid, ex_alu2, ex_dmemwe, ex_regwa, ex_regwe, stall_id;
    logic [3:0]  ex_cb, ex_alusel;
    logic [1:0]  ex_alu1, ex_memlen, ex_regwd;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_sa, ex_wa;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;

    typedef struct {
        bit rst, hold, flush, valid, mid_rst;
        logic [3:0] cb, alusel; logic [1:0] alu1, memlen, regwd;
        logic alu2, dmemwe, regwa, regwe;
        logic [4:0] rs, rt, rd, sa; logic [31:0] rd1, rd2, imm, pc;
    } stim_t;

    typedef struct {
        logic valid; logic [3:0] cb, alusel; logic [1:0] alu1, memlen, regwd;
        logic alu2, dmemwe, regwa, regwe;
        logic [4:0] rs, rt, rd, sa, wa; logic [31:0] rd1, rd2, imm, pc;
    } exp_t;

    exp_t exp_q[$];
    bit   stall_q[$];
    exp_t model_cur;
    exp_t mon_e;
    bit   last_stall;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_cb(id_cb), .id_alu1(id_alu1), .id_alu2(id_alu2), .id_alusel(id_alusel),
        .id_dmemwe(id_dmemwe), .id_memlen(id_memlen), .id_regwa(id_regwa),
        .id_regwd(id_regwd), .id_regwe(id_regwe), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_sa(id_sa), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_pc(id_pc),
        .ex_valid(ex_valid), .ex_cb(ex_cb), .ex_alu1(ex_alu1), .ex_alu2(ex_alu2),
        .ex_alusel(ex_alusel), .ex_dmemwe(ex_dmemwe), .ex_memlen(ex_memlen),
        .ex_regwa(ex_regwa), .ex_regwd(ex_regwd), .ex_regwe(ex_regwe),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_sa(ex_sa),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_wa(ex_wa), .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z = '{valid: 1'b0, cb: 4'd0, alusel: 4'd0, alu1: 2'd0, memlen: 2'd0, regwd: 2'd0,
              alu2: 1'b0, dmemwe: 1'b0, regwa: 1'b0, regwe: 1'b0, rs: 5'd0, rt: 5'd0,
              rd: 5'd0, sa: 5'd0, wa: 5'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0, pc: 32'd0};
        return z;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst: 1'b1, hold: 1'b0, flush: 1'b0, valid: 1'b0, mid_rst: 1'b0,
              cb: CB_NONE, alusel: 4'd0, alu1: 2'd0, memlen: 2'd0, regwd: REGWD_ALU,
              alu2: 1'b0, dmemwe: 1'b0, regwa: REGWA_RD, regwe: 1'b0, rs: 5'd0, rt: 5'd0,
              rd: 5'd0, sa: 5'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0, pc: 32'd0};
        return s;
    endfunction

    // lw $rt, imm($rs)
    function automatic stim_t lw(input logic [4:0] rt, input logic [31:0] pc);
        stim_t s = nop();
        s.valid = 1'b1; s.regwe = 1'b1; s.regwd = REGWD_MEMRD; s.regwa = REGWA_RT;
        s.rs = 5'd29; s.rt = rt; s.imm = 32'h20; s.alu2 = 1'b1; s.pc = pc;
        return s;
    endfunction

    // add $rd, $rs, $rt
    function automatic stim_t add(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] pc);
        stim_t s = nop();
        s.valid = 1'b1; s.regwe = 1'b1; s.regwd = REGWD_ALU; s.regwa = REGWA_RD;
        s.rs = rs; s.rt = rt; s.rd = rd; s.alusel = 4'd2; s.pc = pc;
        s.rd1 = 32'h1111_0000; s.rd2 = 32'h0000_2222;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = nop();
        s.rst    = ($urandom_range(0, 39) != 0);
        s.hold   = ($urandom_range(0, 9) == 0);
        s.flush  = ($urandom_range(0, 9) == 0);
        s.valid  = ($urandom_range(0, 7) != 0);
        s.cb     = ($urandom_range(0, 5) == 0) ? CB_JAL_BR : 4'($urandom);
        s.alusel = 4'($urandom); s.alu1 = 2'($urandom); s.alu2 = 1'($urandom);
        s.dmemwe = 1'($urandom); s.memlen = 2'($urandom); s.regwa = 1'($urandom);
        s.regwd  = 2'($urandom); s.regwe = 1'($urandom);
        s.rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        s.rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        s.rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        s.sa = 5'($urandom); s.rd1 = $urandom; s.rd2 = $urandom;
        s.imm = $urandom; s.pc = $urandom;
        return s;
    endfunction

    // Apply one cycle of stimulus and queue what EX and stall_id must show
    task automatic drive(input stim_t s);
        exp_t nxt;
        bit   hazard, st;
        @(negedge clk);
        rst = s.rst; hold = s.hold; flush = s.flush; id_valid = s.valid;
        id_cb = s.cb; id_alu1 = s.alu1; id_alu2 = s.alu2; id_alusel = s.alusel;
        id_dmemwe = s.dmemwe; id_memlen = s.memlen; id_regwa = s.regwa;
        id_regwd = s.regwd; id_regwe = s.regwe; id_rs = s.rs; id_rt = s.rt;
        id_rd = s.rd; id_sa = s.sa; id_rd1 = s.rd1; id_rd2 = s.rd2;
        id_imm = s.imm; id_pc = s.pc;
        if (!s.rst) model_cur = zero_exp();
        // A load in EX blocks an ID reader of its (nonzero) destination
        hazard = model_cur.valid && model_cur.regwe && (model_cur.regwd == REGWD_MEMRD)
                 && (model_cur.wa != 5'd0) && s.valid
                 && ((model_cur.wa == s.rs) || (model_cur.wa == s.rt));
        st = s.rst && hazard && !s.flush && !s.hold;
        if (!s.rst || s.mid_rst) begin
            nxt = zero_exp();
        end else if (s.hold) begin
            nxt = model_cur;
        end else if (s.flush || hazard) begin
            nxt = zero_exp();
            nxt.pc = s.pc;
        end else begin
            nxt = '{valid: s.valid, cb: s.cb, alusel: s.alusel, alu1: s.alu1,
                    memlen: s.memlen, regwd: s.regwd, alu2: s.alu2, dmemwe: s.dmemwe,
                    regwa: s.regwa, regwe: s.regwe, rs: s.rs, rt: s.rt, rd: s.rd,
                    sa: s.sa, wa: 5'd0, rd1: s.rd1, rd2: s.rd2, imm: s.imm, pc: s.pc};
            nxt.wa = (s.cb == CB_JAL_BR) ? 5'd31 : ((s.regwa == REGWA_RT) ? s.rt : s.rd);
        end
        #1;
        stall_q.push_back(st);
        exp_q.push_back(nxt);
        model_cur  = nxt;
        last_stall = st;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // EX-register monitor: compare just after each active edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
            cmp("ex_cb", 32'(ex_cb), 32'(mon_e.cb));
            cmp("ex_alu1", 32'(ex_alu1), 32'(mon_e.alu1));
            cmp("ex_alu2", 32'(ex_alu2), 32'(mon_e.alu2));
            cmp("ex_alusel", 32'(ex_alusel), 32'(mon_e.alusel));
            cmp("ex_dmemwe", 32'(ex_dmemwe), 32'(mon_e.dmemwe));
            cmp("ex_memlen", 32'(ex_memlen), 32'(mon_e.memlen));
            cmp("ex_regwa", 32'(ex_regwa), 32'(mon_e.regwa));
            cmp("ex_regwd", 32'(ex_regwd), 32'(mon_e.regwd));
            cmp("ex_regwe", 32'(ex_regwe), 32'(mon_e.regwe));
            cmp("ex_rs", 32'(ex_rs), 32'(mon_e.rs));
            cmp("ex_rt", 32'(ex_rt), 32'(mon_e.rt));
            cmp("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
            cmp("ex_sa", 32'(ex_sa), 32'(mon_e.sa));
            cmp("ex_wa", 32'(ex_wa), 32'(mon_e.wa));
            cmp("ex_rd1", ex_rd1, mon_e.rd1);
            cmp("ex_rd2", ex_rd2, mon_e.rd2);
            cmp("ex_imm", ex_imm, mon_e.imm);
            cmp("ex_pc", ex_pc, mon_e.pc);
        end
    end

    // stall_id monitor: compare mid-cycle once inputs have settled
    always @(negedge clk) begin
        #2;
        if (stall_q.size() > 0) cmp("stall_id", 32'(stall_id), 32'(stall_q.pop_front()));
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        stim_t s;
        model_cur = zero_exp();
        last_stall = 1'b0;
        rst = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b1;
        id_cb = 4'd3; id_alu1 = 2'd1; id_alu2 = 1'b1; id_alusel = 4'd5;
        id_dmemwe = 1'b1; id_memlen = 2'd2; id_regwa = 1'b1; id_regwd = 2'd1;
        id_regwe = 1'b1; id_rs = 5'd7; id_rt = 5'd8; id_rd = 5'd9; id_sa = 5'd4;
        id_rd1 = 32'hdead_beef; id_rd2 = 32'h1234_5678; id_imm = 32'h55; id_pc = 32'h100;

        // Reset held with live inputs: EX stays cleared
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 1'b0; s.valid = 1'b1; s.regwe = 1'b1;
            drive(s);
            cmp("rst_stall", 32'(stall_id), 32'd0);
            settle();
            cmp("rst_valid", 32'(ex_valid), 32'd0);
            cmp("rst_regwe", 32'(ex_regwe), 32'd0);
            cmp("rst_pc", ex_pc, 32'd0);
        end

        // Pass-through: addi $5, imm 0x10
        s = nop(); s.valid = 1'b1; s.regwa = REGWA_RT; s.rt = 5'd5; s.rd = 5'd12;
        s.imm = 32'h10; s.regwe = 1'b1; s.alu2 = 1'b1; s.pc = 32'h200;
        drive(s); settle();
        cmp("pt_wa", 32'(ex_wa), 32'd5);
        cmp("pt_imm", ex_imm, 32'h10);
        cmp("pt_valid", 32'(ex_valid), 32'd1);

        // Load-use: lw $8 then add reading $8 -> one bubble, then add loads
        drive(lw(5'd8, 32'h204));
        drive(add(5'd8, 5'd9, 5'd10, 32'h208));
        cmp("lu_stall", 32'(stall_id), 32'd1);
        settle();
        cmp("lu_bubble_regwe", 32'(ex_regwe), 32'd0);
        cmp("lu_bubble_pc", ex_pc, 32'h208);
        drive(add(5'd8, 5'd9, 5'd10, 32'h208));
        cmp("lu_nostall2", 32'(stall_id), 32'd0);
        settle();
        cmp("lu_add_rs", 32'(ex_rs), 32'd8);
        cmp("lu_add_valid", 32'(ex_valid), 32'd1);

        // No false stall: load to $0, and invalid ID
        drive(lw(5'd0, 32'h300));
        drive(add(5'd0, 5'd0, 5'd4, 32'h304));
        cmp("r0_stall", 32'(stall_id), 32'd0);
        drive(lw(5'd8, 32'h308));
        s = add(5'd8, 5'd8, 5'd4, 32'h30c); s.valid = 1'b0;
        drive(s);
        cmp("inv_stall", 32'(stall_id), 32'd0);

        // flush with hazard: flush wins, no stall
        drive(lw(5'd8, 32'h310));
        s = add(5'd8, 5'd1, 5'd2, 32'h314); s.flush = 1'b1;
        drive(s);
        cmp("fl_stall", 32'(stall_id), 32'd0);
        settle();
        cmp("fl_valid", 32'(ex_valid), 32'd0);

        // hold with hazard: frozen two cycles, then hazard re-evaluates
        drive(lw(5'd8, 32'h320));
        for (int i = 0; i < 2; i++) begin
            s = add(5'd1, 5'd8, 5'd2, 32'h324); s.hold = 1'b1;
            drive(s);
            cmp("hold_stall", 32'(stall_id), 32'd0);
            settle();
            cmp("hold_rt", 32'(ex_rt), 32'd8);
            cmp("hold_pc", ex_pc, 32'h320);
        end
        drive(add(5'd1, 5'd8, 5'd2, 32'h324));
        cmp("unhold_stall", 32'(stall_id), 32'd1);

        // jal links to r31
        s = nop(); s.valid = 1'b1; s.cb = CB_JAL_BR; s.pc = 32'h400;
        s.regwe = 1'b1; s.rd = 5'd3;
        drive(s); settle();
        cmp("jal_wa", 32'(ex_wa), 32'd31);
        cmp("jal_pc", ex_pc, 32'h400);

        // Reset mid-cycle clears outputs before the next edge
        s = add(5'd1, 5'd2, 5'd3, 32'h404); s.mid_rst = 1'b1;
        drive(s);
        #2 rst = 1'b0;
        #1;
        cmp("mid_rst_valid", 32'(ex_valid), 32'd0);
        cmp("mid_rst_wa", 32'(ex_wa), 32'd0);
        cmp("mid_rst_pc", ex_pc, 32'd0);
        cmp("mid_rst_stall", 32'(stall_id), 32'd0);
        drive(add(5'd1, 5'd2, 5'd3, 32'h408));
        settle();
        cmp("post_rst_valid", 32'(ex_valid), 32'd1);

        // Random traffic; a stalled instruction is re-presented by ID
        s = rand_stim();
        for (int i = 0; i < 400; i++) begin
            stim_t r;
            r = rand_stim();
            if (last_stall || s.hold) begin
                s.rst = r.rst; s.hold = r.hold; s.flush = r.flush;
            end else begin
                s = r;
            end
            drive(s);
        end

        repeat (2) @(posedge clk);
        #3;
        cmp("queue_drain", exp_q.size() + stall_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
